// File: rtl/dm_pkg.sv
// dm_pkg: DataMover S2MM command/status field layout, typedefs and FSM states.
package dm_pkg;
   localparam int BTT_LSB   = 0;
   localparam int BTT_W     = 23;
   localparam int TYPE_BIT  = 23;
   localparam int DSA_LSB   = 24;
   localparam int DSA_W     = 6;
   localparam int EOF_BIT   = 30;
   localparam int DRR_BIT   = 31;
   localparam int SADDR_LSB = 32;
   localparam int ADDR_W    = 32;
   localparam int TAG_LSB   = 64;
   localparam int TAG_W     = 4;
   localparam int RSVD_LSB  = 68;
   localparam int RSVD_W    = 4;
   localparam int CMD_W     = 72;
   localparam int STS_W     = 8;
   localparam int STS_OKAY   = 7;
   localparam int STS_SLVERR = 6;
   localparam int STS_DECERR = 5;
   localparam int STS_INTERR = 4;

   typedef struct packed {
      logic [RSVD_W-1:0] rsvd;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] saddr;
      logic              drr;
      logic              eof;
      logic [DSA_W-1:0]  dsa;
      logic              typ;
      logic [BTT_W-1:0]  btt;
   } dm_cmd_t;

   typedef struct packed {
      logic             okay;
      logic             slverr;
      logic             decerr;
      logic             interr;
      logic [TAG_W-1:0] tag;
   } dm_sts_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} dm_state_e;
endpackage

// File: rtl/dm_s2mm_cmd_gen.sv
// dm_s2mm_cmd_gen: splits a transfer request into DataMover S2MM commands and tracks their status.
// Define DM_CMD_TAG_CHECK_EN to flag statuses whose tag differs from the expected issue order.
module dm_s2mm_cmd_gen
   import dm_pkg::*;
#(
   parameter int BTT_MAX         = 4096,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              m_axis_s2mm_cmdsts_awclk,
   input  logic              m_axis_s2mm_cmdsts_areset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_len,
   output logic              m_axis_s2mm_cmd_tvalid,
   input  logic              m_axis_s2mm_cmd_tready,
   output logic [CMD_W-1:0]  m_axis_s2mm_cmd_tdata,
   input  logic              s_axis_s2mm_sts_tvalid,
   output logic              s_axis_s2mm_sts_tready,
   input  logic [STS_W-1:0]  s_axis_s2mm_sts_tdata,
   input  logic              s_axis_s2mm_sts_tkeep,
   input  logic              s_axis_s2mm_sts_tlast,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [STS_W-1:0]  err_sts
);
   localparam logic [31:0]      BTT_MAX_W = 32'(BTT_MAX);
   localparam logic [TAG_W-1:0] OUT_MAX   = TAG_W'(MAX_OUTSTANDING);

   dm_state_e        state_q, state_d;
   logic [31:0]      cur_addr_q, cur_addr_d, remaining_q, remaining_d;
   logic [TAG_W-1:0] tag_q, tag_d, exp_tag_q, exp_tag_d, outs_q, outs_d;
   logic             err_q, err_d, done_q, done_d, cmd_vld_q, cmd_vld_d;
   logic [STS_W-1:0] err_sts_q, err_sts_d;
   dm_cmd_t          cmd_q, cmd_d, nxt;
   dm_sts_t          sts;
   logic             accept, hs, sts_acc, sts_bad, tag_bad, err_keep, load;
   logic [BTT_W-1:0] btt_nxt;

   assign sts                    = s_axis_s2mm_sts_tdata;
   assign req_ready              = state_q == ST_IDLE;
   assign s_axis_s2mm_sts_tready = !m_axis_s2mm_cmdsts_areset;
   assign accept                 = req_valid && req_ready;
   assign hs                     = cmd_vld_q && m_axis_s2mm_cmd_tready;
   assign sts_acc                = s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready;

`ifdef DM_CMD_TAG_CHECK_EN
   assign tag_bad = sts.tag != exp_tag_q;
   logic unused_sts;
   assign unused_sts = ^{s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tlast};
`else
   assign tag_bad = 1'b0;
   logic unused_sts;
   assign unused_sts = ^{s_axis_s2mm_sts_tkeep, s_axis_s2mm_sts_tlast, sts.tag};
`endif

   // A status with nothing outstanding is treated as a failure rather than an underflow.
   assign sts_bad = sts_acc && (!sts[STS_OKAY] || sts[STS_SLVERR] || sts[STS_DECERR] ||
                                sts[STS_INTERR] || outs_q == '0 || tag_bad);

   always_comb begin
      cur_addr_d  = accept ? req_addr : hs ? cur_addr_q + 32'(cmd_q.btt) : cur_addr_q;
      remaining_d = accept ? req_len : hs ? remaining_q - 32'(cmd_q.btt) : remaining_q;
      tag_d       = tag_q + TAG_W'(hs);
      exp_tag_d   = exp_tag_q + TAG_W'(sts_acc);
      outs_d      = outs_q + TAG_W'(hs) - TAG_W'(sts_acc && outs_q != '0);
      err_keep    = err_q && !accept;
      err_d       = err_keep || sts_bad;
      err_sts_d   = (sts_bad && !err_keep) ? s_axis_s2mm_sts_tdata : accept ? '0 : err_sts_q;
      state_d     = (state_q == ST_IDLE)  ? ((accept && req_len != '0) ? ST_ISSUE : ST_IDLE) :
                    (state_q == ST_ISSUE) ? ((err_d || (hs && remaining_d == '0)) ? ST_DRAIN : ST_ISSUE) :
                    (outs_q == '0 ? ST_IDLE : ST_DRAIN);
      done_d      = (state_q == ST_IDLE && accept && req_len == '0) ||
                    (state_q == ST_DRAIN && outs_q == '0);
      btt_nxt     = (remaining_d > BTT_MAX_W) ? BTT_MAX_W[BTT_W-1:0] : remaining_d[BTT_W-1:0];
      nxt[RSVD_LSB +: RSVD_W]  = '0;
      nxt[TAG_LSB +: TAG_W]    = tag_d;
      nxt[SADDR_LSB +: ADDR_W] = cur_addr_d;
      nxt[DRR_BIT]             = 1'b0;
      nxt[EOF_BIT]             = remaining_d <= BTT_MAX_W;
      nxt[DSA_LSB +: DSA_W]    = '0;
      nxt[TYPE_BIT]            = 1'b1;
      nxt[BTT_LSB +: BTT_W]    = btt_nxt;
      // The command register is refilled in the same cycle it is consumed, so the next
      // command is built from post-handshake address, length, tag and outstanding count.
      load      = state_d == ST_ISSUE && !err_d && remaining_d != '0 && outs_d < OUT_MAX &&
                  (!cmd_vld_q || hs);
      cmd_vld_d = load || (cmd_vld_q && !hs && !err_d);
      cmd_d     = load ? nxt : cmd_q;
   end

   always_ff @(posedge m_axis_s2mm_cmdsts_awclk) begin
      if (m_axis_s2mm_cmdsts_areset) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         tag_q       <= '0;
         exp_tag_q   <= '0;
         outs_q      <= '0;
         err_q       <= 1'b0;
         err_sts_q   <= '0;
         done_q      <= 1'b0;
         cmd_vld_q   <= 1'b0;
         cmd_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         tag_q       <= tag_d;
         exp_tag_q   <= exp_tag_d;
         outs_q      <= outs_d;
         err_q       <= err_d;
         err_sts_q   <= err_sts_d;
         done_q      <= done_d;
         cmd_vld_q   <= cmd_vld_d;
         cmd_q       <= cmd_d;
      end
   end

   assign m_axis_s2mm_cmd_tvalid = cmd_vld_q;
   assign m_axis_s2mm_cmd_tdata  = cmd_q;
   assign busy                   = state_q != ST_IDLE;
   assign done                   = done_q;
   assign err                    = err_q;
   assign err_sts                = err_sts_q;
endmodule

// File: tb/tb_dm_s2mm_cmd_gen.sv
// tb_dm_s2mm_cmd_gen: directed and randomized checks of dm_s2mm_cmd_gen against a chunking reference model.
module tb_dm_s2mm_cmd_gen;
   localparam int BTT  = 4096;
   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] req_addr = '0, req_len = '0;
   logic        cmd_tvalid, cmd_tready = 1'b0;
   logic [71:0] cmd_tdata;
   logic        sts_tvalid = 1'b0, sts_tready;
   logic [7:0]  sts_tdata = '0;
   logic        busy, done, err;
   logic [7:0]  err_sts;

   dm_s2mm_cmd_gen #(.BTT_MAX(BTT), .MAX_OUTSTANDING(MAXO)) dut (
      .m_axis_s2mm_cmdsts_awclk (clk),
      .m_axis_s2mm_cmdsts_areset(rst),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_addr                (req_addr),
      .req_len                 (req_len),
      .m_axis_s2mm_cmd_tvalid  (cmd_tvalid),
      .m_axis_s2mm_cmd_tready  (cmd_tready),
      .m_axis_s2mm_cmd_tdata   (cmd_tdata),
      .s_axis_s2mm_sts_tvalid  (sts_tvalid),
      .s_axis_s2mm_sts_tready  (sts_tready),
      .s_axis_s2mm_sts_tdata   (sts_tdata),
      .s_axis_s2mm_sts_tkeep   (1'b1),
      .s_axis_s2mm_sts_tlast   (1'b1),
      .busy                    (busy),
      .done                    (done),
      .err                     (err),
      .err_sts                 (err_sts)
   );

   always #5 clk = ~clk;

   int         checks = 0, errors = 0;
   logic [71:0] exp_q[$];
   logic [3:0]  tag_q[$];
   logic [3:0]  mtag = '0;
   int          mout = 0, n_hs = 0, n_done = 0, sts_n = 0, inj_at = 0;
   int          rdy_pct = 100, sts_pct = 100;
   logic [7:0]  inj_val = '0;
   bit          go = 0, force_sts = 0;

   task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Reference: a transfer is cut into BTT-sized pieces at increasing addresses, last one flagged EOF.
   task automatic build(input logic [31:0] a, input logic [31:0] len);
      logic [31:0] off = 0, chunk;
      while (off < len) begin
         chunk = (len - off > BTT) ? BTT : len - off;
         exp_q.push_back({4'h0, mtag, a + off, 1'b0, (off + chunk == len), 6'h0, 1'b1, chunk[22:0]});
         mtag = mtag + 4'd1;
         off += chunk;
      end
   endtask

   task automatic tick();
      logic [7:0]  sb;
      logic [3:0]  t;
      logic [71:0] e;
      @(negedge clk);
      if (done) n_done++;
      if (cmd_tvalid) chk("out_cap", 72'(mout < MAXO), 72'(1));
      req_valid = go;
      if (go) chk("req_ready", 72'(req_ready), 72'(1));
      go = 0;
      cmd_tready = $urandom_range(99) < rdy_pct;
      sts_tvalid = 1'b0;
      if (force_sts || (tag_q.size() > 0 && $urandom_range(99) < sts_pct)) begin
         t = (tag_q.size() > 0) ? tag_q.pop_front() : 4'h0;
         if (mout > 0) mout--;
         sts_n++;
         sb = (sts_n == inj_at) ? inj_val : {4'h8, t};
         sts_tvalid = 1'b1;
         sts_tdata = sb;
      end
      force_sts = 0;
      if (cmd_tvalid && cmd_tready) begin
         n_hs++;
         chk("cmd_expected", 72'(exp_q.size() > 0), 72'(1));
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cmd_tdata", cmd_tdata, e);
            tag_q.push_back(e[67:64]);
            mout++;
         end
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] l);
      req_addr = a;
      req_len = l;
      build(a, l);
      go = 1;
      tick();
   endtask

   task automatic run_until_done(input int budget);
      int d0 = n_done, k = 0;
      while (n_done == d0 && k < budget) begin
         tick();
         k++;
      end
      chk("done_seen", 72'(n_done != d0), 72'(1));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      cmd_tready = 1'b0;
      sts_tvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      tag_q.delete();
      mtag = '0;
      mout = 0;
      @(negedge clk);
   endtask

   initial begin
      int h0, h1, d0, k;
      do_reset();
      chk("rst_req_ready", 72'(req_ready), 72'(1));
      chk("rst_tvalid", 72'(cmd_tvalid), 72'(0));
      chk("rst_tdata", cmd_tdata, 72'(0));
      chk("rst_busy", 72'(busy), 72'(0));
      chk("rst_done", 72'(done), 72'(0));
      chk("rst_err", 72'(err), 72'(0));
      chk("rst_err_sts", 72'(err_sts), 72'(0));
      chk("rst_sts_tready", 72'(sts_tready), 72'(1));

      // Three-chunk transfer with immediate OKAY statuses
      rdy_pct = 100; sts_pct = 100; h0 = n_hs; d0 = n_done;
      start(32'h1000_0000, 10000);
      tick();
      chk("busy_active", 72'(busy), 72'(1));
      chk("req_ready_busy", 72'(req_ready), 72'(0));
      run_until_done(200);
      chk("t1_ncmds", 72'(n_hs - h0), 72'(3));
      repeat (3) tick();
      chk("t1_done_once", 72'(n_done - d0), 72'(1));
      chk("t1_err", 72'(err), 72'(0));
      chk("t1_model_empty", 72'(exp_q.size()), 72'(0));

      // Outstanding limit with withheld status, then release of one
      sts_pct = 0;
      start(32'h2000_0000, 40960);
      h0 = n_hs;
      repeat (15) tick();
      chk("t2_capped", 72'(n_hs - h0), 72'(MAXO));
      chk("t2_tvalid_low", 72'(cmd_tvalid), 72'(0));
      force_sts = 1;
      tick();
      h1 = n_hs;
      tick();
      chk("t2_fifth_next", 72'(n_hs - h1), 72'(1));
      sts_pct = 100;
      run_until_done(500);
      chk("t2_err", 72'(err), 72'(0));

      // Back-pressure: command held stable while tready is low
      rdy_pct = 0;
      start($urandom, 5000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_tvalid_hold", 72'(cmd_tvalid), 72'(1));
         chk("t3_tdata_hold", cmd_tdata, exp_q[0]);
      end
      rdy_pct = 100;
      h0 = n_hs;
      tick();
      chk("t3_single_hs", 72'(n_hs - h0), 72'(1));
      run_until_done(200);

      // SLVERR on second status stops issue and drains
      sts_pct = 0;
      start(32'h3000_0000, 24576);
      repeat (10) tick();
      sts_n = 0; inj_at = 2; inj_val = 8'hC1; sts_pct = 100;
      k = 0;
      while (!err && k < 50) begin
         tick();
         k++;
      end
      chk("t4_err_set", 72'(err), 72'(1));
      h0 = n_hs;
      mtag = mtag - 4'(exp_q.size());
      exp_q.delete();
      run_until_done(200);
      chk("t4_no_more_cmds", 72'(n_hs - h0), 72'(0));
      chk("t4_err_hold", 72'(err), 72'(1));
      chk("t4_err_sts", 72'(err_sts), 72'(8'hC1));
      inj_at = 0;

      // Status 0x85 while tag 0 is expected
      do_reset();
      sts_pct = 0;
      start(32'h4000_0000, 100);
      repeat (3) tick();
      sts_n = 0; inj_at = 1; inj_val = 8'h85; sts_pct = 100;
      run_until_done(100);
`ifdef DM_CMD_TAG_CHECK_EN
      chk("t5_tag_err", 72'(err), 72'(1));
      chk("t5_tag_err_sts", 72'(err_sts), 72'(8'h85));
`else
      chk("t5_tag_ignored", 72'(err), 72'(0));
      chk("t5_tag_err_sts", 72'(err_sts), 72'(0));
`endif
      inj_at = 0;

      // Zero-length request
      d0 = n_done;
      start(32'h5000_0000, 0);
      tick();
      chk("t6_done_next", 72'(n_done - d0), 72'(1));
      chk("t6_no_cmd", 72'(cmd_tvalid), 72'(0));
      chk("t6_busy", 72'(busy), 72'(0));
      chk("t6_err_clear", 72'(err), 72'(0));
      tick();
      chk("t6_done_once", 72'(n_done - d0), 72'(1));

      // Reset while draining, then a stray status
      sts_pct = 0;
      h0 = n_hs;
      start(32'h6000_0000, 8192);
      repeat (6) tick();
      chk("t7_issued", 72'(n_hs - h0), 72'(2));
      chk("t7_draining", 72'(busy), 72'(1));
      chk("t7_tvalid_low", 72'(cmd_tvalid), 72'(0));
      do_reset();
      d0 = n_done;
      chk("t7_req_ready", 72'(req_ready), 72'(1));
      chk("t7_busy", 72'(busy), 72'(0));
      chk("t7_err", 72'(err), 72'(0));
      force_sts = 1;
      tick();
      tick();
      chk("t7_underflow_err", 72'(err), 72'(1));
      chk("t7_underflow_sts", 72'(err_sts), 72'(8'h80));
      chk("t7_no_done", 72'(n_done - d0), 72'(0));

      // Randomized transfers against the model
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rdy_pct = $urandom_range(30, 100);
         sts_pct = $urandom_range(20, 100);
         start((i == 0) ? 32'hFFFF_E800 : $urandom, $urandom_range(1, 20000));
         run_until_done(3000);
         chk("rnd_err", 72'(err), 72'(0));
         chk("rnd_model_empty", 72'(exp_q.size()), 72'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dm_s2mm_cmd_gen.md
DM_S2MM_CMD_GEN -- requirements
Module: dm_s2mm_cmd_gen

Interface
REQ-001 SHALL have parameter BTT_MAX, default 4096, max bytes per DataMover command (1..8388607).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, max issued commands awaiting status (1..15).
REQ-003 SHALL have port m_axis_s2mm_cmdsts_awclk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port m_axis_s2mm_cmdsts_areset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1: transfer-request handshake.
REQ-006 SHALL have ports req_addr in 32 (start byte address) and req_len in 32 (total bytes).
REQ-007 SHALL have ports m_axis_s2mm_cmd_tvalid out 1, m_axis_s2mm_cmd_tready in 1, m_axis_s2mm_cmd_tdata out 72: command stream to the DataMover.
REQ-008 SHALL have ports s_axis_s2mm_sts_tvalid in 1, s_axis_s2mm_sts_tready out 1, s_axis_s2mm_sts_tdata in 8, s_axis_s2mm_sts_tkeep in 1, s_axis_s2mm_sts_tlast in 1: status stream from the DataMover; tkeep/tlast ignored.
REQ-009 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1, err_sts out 8 (first failing status byte).

Function
REQ-010 SHALL run FSM IDLE -> ISSUE -> DRAIN -> IDLE; req_ready=1 only in IDLE.
REQ-011 On req_valid&&req_ready: latch addr/len into cur_addr/remaining, clear err/err_sts, go ISSUE; if req_len==0, pulse done next cycle, issue no command, stay IDLE.
REQ-012 Command fields: [22:0] BTT=min(remaining,BTT_MAX), [23] TYPE=1, [29:24] DSA=0, [30] EOF=1 only on final chunk, [31] DRR=0, [63:32] SADDR=cur_addr, [67:64] TAG=issue tag, [71:68]=0.
REQ-013 cmd_tdata/tvalid SHALL be registered and held stable while tvalid&&!tready.
REQ-014 On cmd handshake: cur_addr+=BTT (32-bit wrap), remaining-=BTT, issue tag+=1 mod 16, outstanding+=1.
REQ-015 cmd_tvalid SHALL be 0 when outstanding==MAX_OUTSTANDING, remaining==0, or err==1.
REQ-016 ISSUE->DRAIN when remaining==0 after a handshake, or when err sets.
REQ-017 s_axis_s2mm_sts_tready SHALL be 1 whenever not in reset; each accepted status decrements outstanding, expected tag += 1 mod 16.
REQ-018 Same-cycle cmd handshake and status accept SHALL leave outstanding unchanged.
REQ-019 A status with bit7 OKAY=0 or any of bits[6:4] set SHALL set err sticky and capture err_sts, first failure only.
REQ-020 DRAIN->IDLE when outstanding==0; done pulses exactly one cycle on that transition.
REQ-021 A status accepted while outstanding==0 SHALL set err with err_sts=status and not underflow outstanding.
REQ-022 busy=1 in ISSUE and DRAIN.

Reset
REQ-023 Reset SHALL force IDLE; req_ready=1 the cycle after reset deasserts; cmd_tvalid, cmd_tdata, busy, done, err, err_sts, outstanding, both tags = 0.
REQ-024 Reset mid-transfer SHALL discard all state; subsequent statuses follow REQ-021.

Configuration
REQ-025 With DM_CMD_TAG_CHECK_EN defined, status tag[3:0] != expected tag SHALL set err and capture err_sts; without it, tag is ignored and no tag-compare logic is built.

Structure
REQ-026 Package dm_pkg SHALL hold command field offsets/widths, status bit positions, typedefs dm_cmd_t (72-bit packed struct) and dm_sts_t (8-bit packed struct).
REQ-027 No sub-module; single module, counters and FSM inline.

Verification
REQ-028 addr=0x1000_0000, len=10000, BTT_MAX=4096, all OKAY status (0x80|tag) -> 3 cmds BTT 4096/4096/1808, SADDR 0x10000000/0x10001000/0x10002000, EOF only on 3rd, tags 0/1/2, done one pulse, err=0.
REQ-029 len=40960, MAX_OUTSTANDING=4, status withheld -> exactly 4 cmds issued, tvalid low; releasing one status -> 5th cmd issued next cycle.
REQ-030 cmd_tready held low 5 cycles -> cmd_tdata unchanged all 5 cycles; single handshake on release.
REQ-031 2nd status 0xC1 (SLVERR) -> err=1, err_sts=0xC1, no further cmds, done after outstanding drains.
REQ-032 Tag-check build, status 0x85 when tag 0 expected -> err=1, err_sts=0x85; non-check build -> err=0.
REQ-033 len=0 -> no cmd_tvalid, done pulse next cycle; reset during DRAIN -> IDLE, outstanding=0, done not pulsed.
